// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Each accepted operation returns its result on a valid/ready channel tagged with the requester ID.
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int DATA_W  = 32,
    parameter int OP_W    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic [DATA_W-1:0]         alu_result,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] idx;
    logic            grant_found;

    // Walk offsets from the far end so the requester closest to rr_ptr wins.
    always_comb begin
        grant       = rr_ptr;
        grant_found = 1'b0;
        idx         = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                grant       = idx;
                grant_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (reset && (state == IDLE) && grant_found) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        alu_op  <= req_op[int'(grant)*OP_W +: OP_W];
                        alu_a   <= req_a[int'(grant)*DATA_W +: DATA_W];
                        alu_b   <= req_b[int'(grant)*DATA_W +: DATA_W];
                        resp_id <= grant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    resp_data  <= alu_result;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        rr_ptr     <= (resp_id == ID_W'(NUM_REQ - 1)) ? '0 : resp_id + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a transaction-level model predicts grants and responses,
// a separate monitor compares every presented response against the expected queue.
module tb_alu_arbiter;
    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int DW   = 32;
    localparam int OW   = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [OW*N-1:0]   req_op;
    logic [DW*N-1:0]   req_a;
    logic [DW*N-1:0]   req_b;
    logic [OW-1:0]     alu_op;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [DW-1:0]     alu_result;
    logic              resp_valid;
    logic              resp_ready;
    logic [ID_W-1:0]   resp_id;
    logic [DW-1:0]     resp_data;
    logic              busy;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   data;
    } resp_t;

    logic [OW-1:0] op_arr[N];
    logic [DW-1:0] a_arr[N];
    logic [DW-1:0] b_arr[N];
    resp_t         exp_q[$];
    int            vectors     = 0;
    int            miscompares = 0;

    // Model state: 0 = free, 1 = computing, 2 = holding response.
    int            m_phase = 0;
    int            m_rr    = 0;
    int            m_id    = 0;
    bit            m_known = 1'b0;

    always #5 clock = ~clock;

    // ALU stub: addition, independent of opcode.
    assign alu_result = alu_a + alu_b;

    alu_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .DATA_W(DW), .OP_W(OW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (v[j[ID_W-1:0]]) return j;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check predicted handshake signals, advance the model.
    task automatic apply_stimulus(input logic [N-1:0] v, input logic rdy, input logic rst);
        logic [N-1:0] exp_ready;
        int           g;
        @(negedge clock);
        reset      = rst;
        req_valid  = v;
        resp_ready = rdy;
        for (int i = 0; i < N; i++) begin
            req_op[i*OW +: OW] = op_arr[i];
            req_a[i*DW +: DW]  = a_arr[i];
            req_b[i*DW +: DW]  = b_arr[i];
        end
        #1;
        g = model_grant(v);
        exp_ready = '0;
        if (rst && m_known && m_phase == 0 && g >= 0) exp_ready = N'(1) << g;
        if (m_known || !rst) check_output("req_ready", 64'(req_ready), 64'(exp_ready));
        if (m_known) begin
            check_output("busy", 64'(busy), 64'(m_phase != 0));
            check_output("resp_valid", 64'(resp_valid), 64'(m_phase == 2));
        end
        if (!rst) begin
            m_phase = 0;
            m_rr    = 0;
            m_known = 1'b1;
            exp_q.delete();
        end else if (m_known) begin
            case (m_phase)
                0: if (g >= 0) begin
                    exp_q.push_back({ID_W'(g), a_arr[g] + b_arr[g]});
                    m_id    = g;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rdy) begin
                    m_rr    = (m_id + 1) % N;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    // Response monitor: every presented response must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL resp_unexpected: got id %0d data %0h, expected no response", resp_id, resp_data);
                end else begin
                    check_output("resp_id", 64'(resp_id), 64'(exp_q[0].id));
                    check_output("resp_data", 64'(resp_data), 64'(exp_q[0].data));
                    if (resp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            op_arr[i] = '0;
            a_arr[i]  = '0;
            b_arr[i]  = '0;
        end
        apply_stimulus(4'b0000, 1'b0, 1'b0);
        apply_stimulus(4'b0000, 1'b0, 1'b0);

        // Single request: 5 + 3 from requester 0.
        a_arr[0] = 32'h5;
        b_arr[0] = 32'h3;
        apply_stimulus(4'b0001, 1'b1, 1'b1);
        repeat (4) apply_stimulus(4'b0000, 1'b1, 1'b1);

        // All requesters valid continuously, starting from a fresh pointer.
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) begin
            a_arr[i] = DW'(i);
            b_arr[i] = 32'h10;
        end
        repeat (15) apply_stimulus(4'b1111, 1'b1, 1'b1);
        repeat (3) apply_stimulus(4'b0000, 1'b1, 1'b1);

        // Backpressure: hold the response while everyone requests.
        apply_stimulus(4'b0001, 1'b0, 1'b1);
        repeat (8) apply_stimulus(4'b1111, 1'b0, 1'b1);
        repeat (4) apply_stimulus(4'b1111, 1'b1, 1'b1);
        repeat (3) apply_stimulus(4'b0000, 1'b1, 1'b1);

        // Wrap-around: grant 3, then 1 and 3 compete.
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        apply_stimulus(4'b1000, 1'b1, 1'b1);
        repeat (2) apply_stimulus(4'b0000, 1'b1, 1'b1);
        repeat (6) apply_stimulus(4'b1010, 1'b1, 1'b1);
        repeat (3) apply_stimulus(4'b0000, 1'b1, 1'b1);

        // Reset during EXEC drops the in-flight operation.
        apply_stimulus(4'b0100, 1'b1, 1'b1);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        apply_stimulus(4'b1000, 1'b1, 1'b1);
        apply_stimulus(4'b0000, 1'b1, 1'b0);
        apply_stimulus(4'b0000, 1'b1, 1'b1);
        check_output("rst_resp_valid", 64'(resp_valid), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_resp_data", 64'(resp_data), 64'd0);
        repeat (4) apply_stimulus(4'b1111, 1'b1, 1'b1);

        // Requester 2 pulses only while a response is stalled.
        repeat (3) apply_stimulus(4'b0000, 1'b1, 1'b1);
        apply_stimulus(4'b0001, 1'b0, 1'b1);
        apply_stimulus(4'b0000, 1'b0, 1'b1);
        apply_stimulus(4'b0100, 1'b0, 1'b1);
        apply_stimulus(4'b0000, 1'b0, 1'b1);
        repeat (4) apply_stimulus(4'b0000, 1'b1, 1'b1);

        // Randomized traffic and backpressure.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                op_arr[i] = OW'($urandom);
                a_arr[i]  = $urandom;
                b_arr[i]  = $urandom;
            end
            apply_stimulus(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), 1'b1);
        end
        repeat (5) apply_stimulus(4'b0000, 1'b1, 1'b1);
        check_output("pending_responses", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
